// File: rtl/ddr_mrs_sequencer.sv
// ---------------------------------------------------------------------------
// ddr_mrs_sequencer
//
// Purpose:
//   Issues the four DDR3 mode-register-set (MRS) commands in JEDEC order
//   (MR2, MR3, MR1, MR0) from the msr0..msr3 config values on a single start
//   pulse. tMRD is enforced between MRS commands, and tMOD is enforced after
//   the last one. A one-cycle done pulse then closes the sequence.
//
// Ports:
//   clk        in   1   sole clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   1-cycle request to run the MRS sequence
//   msr0..3    in   19  config: [18:16]=bank addr BA, [15:0]=row addr A
//   cmd_valid  out  1   MRS command present
//   cmd_ready  in   1   scheduler accepts command (valid&ready = transfer)
//   cmd_ba     out  3   bank address of current MRS (selects MR0..MR3)
//   cmd_addr   out  16  address/opcode of current MRS
//   busy       out  1   sequence in progress (start ignored while high)
//   done       out  1   1-cycle pulse: sequence complete, tMOD satisfied
// ---------------------------------------------------------------------------
module ddr_mrs_sequencer #(
  parameter int T_MRD = 4,   // acceptance -> next cmd_valid, in cycles
  parameter int T_MOD = 12,  // MR0 acceptance -> done, in cycles
  parameter int CNT_W = 5    // wait counter width
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [18:0] msr0,
  input  logic [18:0] msr1,
  input  logic [18:0] msr2,
  input  logic [18:0] msr3,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_ba,
  output logic [15:0] cmd_addr,
  output logic        busy,
  output logic        done
);

  localparam int LP_MAX_T = (T_MRD > T_MOD) ? T_MRD : T_MOD;

  // Refuse to build with timings the counter cannot represent.
  generate
    if ((T_MRD < 1) || (T_MOD < 1) || ((LP_MAX_T - 1) >= (1 << CNT_W))) begin : g_bad_params
      $error("ddr_mrs_sequencer: need T_MRD>=1, T_MOD>=1 and max(T_MRD,T_MOD)-1 < 2**CNT_W");
    end
  endgenerate

  // The counter is loaded with T-1 and the state exits when the decremented
  // value reaches zero. A wait state therefore lasts T-1 cycles, and the
  // event follows exactly T cycles after the acceptance. With T==1 the wait
  // state is skipped entirely.
  localparam logic [CNT_W-1:0] LP_MRD_LOAD = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LP_MOD_LOAD = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_MOD,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_xfer;

  // Snapshot held in issue order: [0]=MR2, [1]=MR3, [2]=MR1, [3]=MR0.
  logic [3:0][18:0] r_snap;
  logic [3:0][18:0] w_snap_src;
  logic [18:0]      w_cmd;
  logic [2:0]       r_cmd_ba;
  logic [15:0]      r_cmd_addr;

  // On the start cycle the snapshot is not yet written, so the first command
  // is taken straight from the inputs being captured.
  assign w_snap_src = w_load ? {msr0, msr1, msr3, msr2} : r_snap;
  assign w_cmd      = w_snap_src[w_idx_nxt];

  assign cmd_valid = (r_state == S_ISSUE);
  assign w_xfer    = cmd_valid & cmd_ready;
  assign busy      = (r_state == S_ISSUE) || (r_state == S_GAP) || (r_state == S_MOD);
  assign done      = (r_state == S_FIN);
  assign cmd_ba    = r_cmd_ba;
  assign cmd_addr  = r_cmd_addr;

  // NOTE: every signal assigned here gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (w_xfer) begin
          if (r_idx != 2'd3) begin
            w_idx_nxt = r_idx + 2'd1;
            w_cnt_nxt = LP_MRD_LOAD;
            if (T_MRD > 1) begin
              w_state_nxt = S_GAP;
            end
          end else begin
            w_cnt_nxt   = LP_MOD_LOAD;
            w_state_nxt = (T_MOD > 1) ? S_MOD : S_FIN;
          end
        end
      end

      S_GAP: begin
        w_cnt_nxt = r_cnt - LP_ONE;
        if (r_cnt == LP_ONE) begin
          w_state_nxt = S_ISSUE;
        end
      end

      S_MOD: begin
        w_cnt_nxt = r_cnt - LP_ONE;
        if (r_cnt == LP_ONE) begin
          w_state_nxt = S_FIN;
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      // NOTE: the snapshot is cleared on reset as well, so a sequence killed
      // by reset leaves no stale configuration behind.
      r_snap     <= '0;
      r_cmd_ba   <= 3'd0;
      r_cmd_addr <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_snap <= w_snap_src;
      end
      // Command fields only change when a command is about to be presented.
      // They hold through a stall and keep their last value while idle.
      if (w_state_nxt == S_ISSUE) begin
        r_cmd_ba   <= w_cmd[18:16];
        r_cmd_addr <= w_cmd[15:0];
      end
    end
  end

endmodule

// File: tb/tb_ddr_mrs_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ddr_mrs_sequencer
//
// Bench for ddr_mrs_sequencer. Two instances are used: u_dut has the default
// timing (T_MRD=4, T_MOD=12), and u_dut1 has T_MRD=1, T_MOD=1.
//
// The stimulus pushes hand-written expected commands and done delays into
// queues. A monitor on the falling edge pops the queues and compares them
// against whichever instance is selected.
// ---------------------------------------------------------------------------
module tb_ddr_mrs_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        ready = 1'b1;
  logic [18:0] msr0 = 19'h0_0520;
  logic [18:0] msr1 = 19'h1_0044;
  logic [18:0] msr2 = 19'h2_0008;
  logic [18:0] msr3 = 19'h3_0000;

  logic        v0, b0, d0, v1, b1, d1;
  logic [2:0]  ba0, ba1;
  logic [15:0] a0, a1;

  always #5 clk = ~clk;

  ddr_mrs_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .msr0(msr0), .msr1(msr1), .msr2(msr2), .msr3(msr3),
    .cmd_valid(v0), .cmd_ready(ready), .cmd_ba(ba0), .cmd_addr(a0),
    .busy(b0), .done(d0)
  );

  ddr_mrs_sequencer #(.T_MRD(1), .T_MOD(1), .CNT_W(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .msr0(msr0), .msr1(msr1), .msr2(msr2), .msr3(msr3),
    .cmd_valid(v1), .cmd_ready(ready), .cmd_ba(ba1), .cmd_addr(a1),
    .busy(b1), .done(d1)
  );

  // Monitored instance selection.
  bit          sel = 1'b0;
  logic        m_valid, m_busy, m_done, m_start;
  logic [2:0]  m_ba;
  logic [15:0] m_addr;
  assign m_valid = sel ? v1 : v0;
  assign m_busy  = sel ? b1 : b0;
  assign m_done  = sel ? d1 : d0;
  assign m_start = sel ? start1 : start0;
  assign m_ba    = sel ? ba1 : ba0;
  assign m_addr  = sel ? a1 : a0;

  typedef struct {
    logic [2:0]  ba;
    logic [15:0] addr;
    int          gap;  // cycles from previous acceptance (or start) to cmd_valid
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];   // expected cycles from MR0 acceptance to done
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    int          last_acc;
    int          first_cyc;
    bit          prev_valid;
    bit          prev_xfer;
    bit          prev_stall;
    logic [2:0]  prev_ba;
    logic [15:0] prev_addr;
    exp_t        e;
    int          dly;
    last_acc   = 0;
    first_cyc  = 0;
    prev_valid = 1'b0;
    prev_xfer  = 1'b0;
    prev_stall = 1'b0;
    prev_ba    = '0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (m_start && !m_busy && !m_done) last_acc = cyc;
        if (prev_stall) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_ba", 32'(m_ba), 32'(prev_ba));
          check("hold_addr", 32'(m_addr), 32'(prev_addr));
        end
        if (m_valid && (!prev_valid || prev_xfer)) first_cyc = cyc;
        if (m_valid && ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got ba=%0h addr=%0h, expected no command (cycle %0d)",
                     m_ba, m_addr, cyc);
          end else begin
            e = exp_q.pop_front();
            check("cmd_ba", 32'(m_ba), 32'(e.ba));
            check("cmd_addr", 32'(m_addr), 32'(e.addr));
            check("cmd_gap", 32'(first_cyc - last_acc), 32'(e.gap));
            check("busy_in_cmd", 32'(m_busy), 32'd1);
          end
          last_acc = cyc;
        end
        if (m_done) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
          end else begin
            dly = done_q.pop_front();
            check("done_delay", 32'(cyc - last_acc), 32'(dly));
            check("busy_at_done", 32'(m_busy), 32'd0);
          end
        end
        prev_valid = m_valid;
        prev_xfer  = m_valid && ready;
        prev_stall = m_valid && !ready;
        prev_ba    = m_ba;
        prev_addr  = m_addr;
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Expected MRS order for msr0..3 = 0_0520, 1_0044, 2_0008, 3_0000.
  task automatic push_seq(input int tmrd, input int tmod);
    exp_q.push_back('{ba: 3'd2, addr: 16'h0008, gap: 1});
    exp_q.push_back('{ba: 3'd3, addr: 16'h0000, gap: tmrd});
    exp_q.push_back('{ba: 3'd1, addr: 16'h0044, gap: tmrd});
    exp_q.push_back('{ba: 3'd0, addr: 16'h0520, gap: tmrd});
    done_q.push_back(tmod);
  endtask

  // Waits for the scoreboard to drain, then idles a few more cycles.
  task automatic wait_idle(input string name, input int budget, input int extra);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size() + done_q.size()), 32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (extra) tick();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_ba", 32'(ba0), 32'd0);
    check("rst_addr", 32'(a0), 32'd0);
    check("rst_busy", 32'(b0), 32'd0);
    check("rst_done", 32'(d0), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: basic sequence, ready tied high
    push_seq(4, 12);
    pulse_start();
    wait_idle("t1", 100, 5);

    // 2: second command stalled 7 cycles
    push_seq(4, 12);
    pulse_start();          // now in cycle S+1, first command valid
    repeat (4) tick();      // cycle S+5: second command valid
    ready = 1'b0;
    repeat (7) tick();
    ready = 1'b1;
    wait_idle("t2", 100, 5);

    // 3: config change after start is ignored
    push_seq(4, 12);
    pulse_start();
    msr1 = 19'h1_7FFF;
    wait_idle("t3", 100, 5);
    msr1 = 19'h1_0044;

    // 4: start during GAP and during MOD is ignored
    push_seq(4, 12);
    pulse_start();          // cycle S+1
    repeat (2) tick();      // S+3: GAP after MR2
    pulse_start();          // S+4
    repeat (14) tick();     // S+18: MOD after MR0 accepted at S+13
    pulse_start();
    wait_idle("t4", 100, 30);

    // 5: reset during the GAP after MR3
    exp_q.push_back('{ba: 3'd2, addr: 16'h0008, gap: 1});
    exp_q.push_back('{ba: 3'd3, addr: 16'h0000, gap: 4});
    pulse_start();          // S+1
    repeat (6) tick();      // S+7: GAP after MR3 (accepted S+5)
    check("t5_pre_ba", 32'(ba0), 32'd3);
    check("t5_pre_busy", 32'(b0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(v0), 32'd0);
    check("t5_rst_ba", 32'(ba0), 32'd0);
    check("t5_rst_addr", 32'(a0), 32'd0);
    check("t5_rst_busy", 32'(b0), 32'd0);
    check("t5_rst_done", 32'(d0), 32'd0);
    check("t5_two_cmds", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("t5_idle_valid", 32'(v0), 32'd0);
    check("t5_idle_busy", 32'(b0), 32'd0);
    push_seq(4, 12);
    pulse_start();
    wait_idle("t5", 100, 5);

    // 6: T_MRD=1, T_MOD=1 instance
    sel = 1'b1;
    repeat (2) tick();
    push_seq(1, 1);
    pulse_start();
    wait_idle("t6", 50, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
